// File: rtl/io_pkg.sv
// Register map indices and BSTAT bit positions shared by the LED/switch/button I/O port.
package io_pkg;
    localparam logic [3:0] IO_REG_LED   = 4'd0;
    localparam logic [3:0] IO_REG_SW    = 4'd1;
    localparam logic [3:0] IO_REG_BSTAT = 4'd2;
    localparam logic [3:0] IO_REG_IEN   = 4'd3;
    localparam logic [3:0] IO_REG_CYC   = 4'd4;
    localparam logic [3:0] IO_REG_SCR   = 4'd5;

    localparam int IO_BSTAT_LVL  = 0;
    localparam int IO_BSTAT_PEND = 1;
endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw input.
// RISE is high during the cycle whose edge raises LEVEL from 0 to 1.
module io_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic RAW,
    output logic LEVEL,
    output logic RISE
);
    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             differ, done;

    always_comb begin
        sync_d  = {sync_q[0], RAW};
        differ  = sync_q[1] ^ level_q;
        done    = differ && (cnt_q == CNT_LAST);
        level_d = level_q;
        cnt_d   = '0;
        // Counter stops at CNT_LAST: that cycle flips the level and restarts from 0.
        if (done) begin
            level_d = ~level_q;
        end else if (differ) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign LEVEL = level_q;
    assign RISE  = done & ~level_q;
endmodule

// File: rtl/io_leds_port.sv
// Board-side responder for the CPU I/O port: LED/switch/button register bank and INT_BTN.
// Define IO_CYCLE_COUNTER_EN to implement the free-running CYC register at index 4.
module io_leds_port
    import io_pkg::*;
#(
    parameter int LED_W      = 8,
    parameter int SW_W       = 8,
    parameter int DEB_CYCLES = 50000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             LEDS_WE,
    input  logic [31:0]      LEDS_WD,
    input  logic [3:0]       LEDS_A,
    output logic [31:0]      LEDS_RD,
    output logic             INT_BTN,
    output logic [LED_W-1:0] LEDS,
    input  logic [SW_W-1:0]  SW,
    input  logic             BTN
);
    logic [LED_W-1:0] led_q, led_d;
    logic [SW_W-1:0]  sw_meta_q, sw_meta_d;
    logic [SW_W-1:0]  sw_sync_q, sw_sync_d;
    logic             ien_q, ien_d;
    logic             pend_q, pend_d;
    logic             int_q, int_d;
    logic [31:0]      scr_q, scr_d;
    logic             btn_level, btn_rise;
    logic             wr_led, wr_bstat, wr_ien, wr_scr;

    io_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn_deb (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .RAW    (BTN),
        .LEVEL  (btn_level),
        .RISE   (btn_rise)
    );

    always_comb begin
        wr_led    = LEDS_WE && (LEDS_A == IO_REG_LED);
        wr_bstat  = LEDS_WE && (LEDS_A == IO_REG_BSTAT);
        wr_ien    = LEDS_WE && (LEDS_A == IO_REG_IEN);
        wr_scr    = LEDS_WE && (LEDS_A == IO_REG_SCR);
        sw_meta_d = SW;
        sw_sync_d = sw_meta_q;
        led_d     = wr_led ? LEDS_WD[LED_W-1:0] : led_q;
        ien_d     = wr_ien ? LEDS_WD[0] : ien_q;
        scr_d     = wr_scr ? LEDS_WD : scr_q;
        // A press landing in the same cycle as a W1C keeps PEND set.
        pend_d    = pend_q;
        if (btn_rise) begin
            pend_d = 1'b1;
        end else if (wr_bstat && LEDS_WD[IO_BSTAT_PEND]) begin
            pend_d = 1'b0;
        end
        int_d     = pend_q & ien_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            ien_q     <= 1'b0;
            pend_q    <= 1'b0;
            int_q     <= 1'b0;
            scr_q     <= '0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            ien_q     <= ien_d;
            pend_q    <= pend_d;
            int_q     <= int_d;
            scr_q     <= scr_d;
        end
    end

`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] cyc_q, cyc_d;

    // A write clears the counter regardless of data and overrides the increment.
    always_comb begin
        cyc_d = (LEDS_WE && (LEDS_A == IO_REG_CYC)) ? 32'd0 : cyc_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end
`endif

    always_comb begin
        LEDS_RD = '0;
        case (LEDS_A)
            IO_REG_LED:   LEDS_RD[LED_W-1:0] = led_q;
            IO_REG_SW:    LEDS_RD[SW_W-1:0]  = sw_sync_q;
            IO_REG_BSTAT: begin
                LEDS_RD[IO_BSTAT_LVL]  = btn_level;
                LEDS_RD[IO_BSTAT_PEND] = pend_q;
            end
            IO_REG_IEN:   LEDS_RD[0] = ien_q;
`ifdef IO_CYCLE_COUNTER_EN
            IO_REG_CYC:   LEDS_RD = cyc_q;
`endif
            IO_REG_SCR:   LEDS_RD = scr_q;
            default:      LEDS_RD = '0;
        endcase
    end

    assign LEDS    = led_q;
    assign INT_BTN = int_q;
endmodule
